if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch.sv | 166 ++++++++++++++++
 tb/tb_if_fetch.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// if_fetch: instruction fetch front end.
// Takes fetch addresses from the program counter, issues them to instruction
// memory with a req/gnt handshake, pairs in-order responses with their request
// addresses and buffers them for decode. A redirect (flush_i) empties the buffer
// and marks every in-flight response to be discarded on arrival.
//
// Ports
//   clk, rstn            clock (rising edge), async active-low reset
//   pc_i/pc_valid_i      next fetch address from PC
//   pc_ready_o           address accepted this cycle
//   hold_i               pipeline hold, blocks address acceptance
//   flush_i              redirect, discards buffered and in-flight fetches
//   imem_req_o/addr_o    memory request and address (registered)
//   imem_gnt_i           request accepted by memory
//   imem_rvalid_i/rdata_i read response, in request order
//   inst_valid_o/inst_o/inst_addr_o  buffered instruction to decode
//   inst_ready_i         decode consumes instruction
//   err_o                sticky: response arrived with nothing outstanding
//
// state    | meaning
// IDLE     | no request on the bus; may accept a new fetch address
// WAIT_GNT | imem_req_o held high with a stable address until granted
module if_fetch #(
  parameter int BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] pc_i,
  input  logic        pc_valid_i,
  output logic        pc_ready_o,
  input  logic        hold_i,
  input  logic        flush_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_ready_i,
  output logic        err_o
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int PW = $clog2(BUF_DEPTH);

  typedef enum logic {IDLE = 1'b0, WAIT_GNT = 1'b1} state_t;

  state_t          state;
  logic [CW-1:0]   out_cnt;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_cnt;
  logic [PW-1:0]   f_wr, f_rd;
  logic [PW-1:0]   a_wr, a_rd;
  logic [31:0]     f_data [BUF_DEPTH];
  logic [31:0]     f_addr [BUF_DEPTH];
  logic [31:0]     a_q    [BUF_DEPTH];

  logic            accept;
  logic            gnt_hit;
  logic            rv_ok;
  logic            push;
  logic            pop;
  logic [CW:0]     credit_used;

  // Outstanding requests plus buffered entries never exceed BUF_DEPTH, so every
  // response that is kept always finds a free FIFO slot.
  assign credit_used  = {1'b0, out_cnt} + {1'b0, fifo_cnt};
  assign pc_ready_o   = (state == IDLE) && !hold_i && !flush_i &&
                        (credit_used < (CW+1)'(BUF_DEPTH));
  assign accept       = pc_valid_i && pc_ready_o;
  assign gnt_hit      = (state == WAIT_GNT) && imem_gnt_i;
  assign rv_ok        = imem_rvalid_i && (out_cnt != '0);
  assign push         = rv_ok && (drop_cnt == '0) && !flush_i;
  assign inst_valid_o = (fifo_cnt != '0) && !flush_i;
  assign pop          = inst_valid_o && inst_ready_i;
  assign inst_o       = f_data[f_rd];
  assign inst_addr_o  = f_addr[f_rd];

  // Request FSM; flush and hold do not abort a pending request.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      imem_req_o  <= 1'b0;
      imem_addr_o <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            imem_addr_o <= pc_i;
            imem_req_o  <= 1'b1;
            state       <= WAIT_GNT;
          end
        end
        WAIT_GNT: begin
          if (imem_gnt_i) begin
            imem_req_o <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // In-flight accounting. On flush, every request still owed a response
  // (including one not yet granted) becomes a response to discard.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_cnt  <= '0;
      drop_cnt <= '0;
      err_o    <= 1'b0;
    end else begin
      out_cnt <= out_cnt + CW'(gnt_hit) - CW'(rv_ok);
      if (flush_i)
        drop_cnt <= out_cnt - CW'(rv_ok) + CW'(state == WAIT_GNT);
      else if (rv_ok && (drop_cnt != '0))
        drop_cnt <= drop_cnt - CW'(1);
      if (imem_rvalid_i && (out_cnt == '0))
        err_o <= 1'b1;
    end
  end

  // Address queue: one entry per granted request, popped by each response,
  // dropped ones included, so the head always matches the next response.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_wr <= '0;
      a_rd <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) a_q[i] <= 32'h0;
    end else begin
      if (gnt_hit) begin
        a_q[a_wr] <= imem_addr_o;
        a_wr      <= a_wr + PW'(1);
      end
      if (rv_ok) a_rd <= a_rd + PW'(1);
    end
  end

  // Instruction buffer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      f_wr     <= '0;
      f_rd     <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        f_data[i] <= 32'h0;
        f_addr[i] <= 32'h0;
      end
    end else if (flush_i) begin
      f_wr     <= '0;
      f_rd     <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        f_data[f_wr] <= imem_rdata_i;
        f_addr[f_wr] <= a_q[a_rd];
        f_wr         <= f_wr + PW'(1);
      end
      if (pop) f_rd <= f_rd + PW'(1);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: self-checking bench for if_fetch (BUF_DEPTH = 2).
// Kept responses are pushed to a scoreboard when the bench drives rvalid and
// compared against inst_addr_o/inst_o when decode consumes them; any
// instruction presented while nothing is expected is flagged.
module tb_if_fetch;

  logic        clk;
  logic        rstn;
  logic [31:0] pc_i;
  logic        pc_valid_i;
  logic        pc_ready_o;
  logic        hold_i;
  logic        flush_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_ready_i;
  logic        err_o;

  int          n_cmp;
  int          n_err;
  logic [63:0] sb_q[$];
  logic [63:0] mon_exp;

  if_fetch #(.BUF_DEPTH(2)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .pc_i         (pc_i),
    .pc_valid_i   (pc_valid_i),
    .pc_ready_o   (pc_ready_o),
    .hold_i       (hold_i),
    .flush_i      (flush_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .inst_ready_i (inst_ready_i),
    .err_o        (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a);
    bit done;
    done       = 1'b0;
    pc_i       = a;
    pc_valid_i = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (pc_ready_o) done = 1'b1;
      step();
    end
    pc_valid_i = 1'b0;
    chk("issue_accept", 64'(done), 64'd1);
  endtask

  task automatic grant(input int dly);
    chk("grant_req", 64'(imem_req_o), 64'd1);
    for (int i = 0; i < dly; i++) step();
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d, input logic [31:0] a, input bit keep);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = d;
    if (keep) sb_q.push_back({a, d});
    step();
    imem_rvalid_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) step();
    chk("drain", 64'(sb_q.size()), 64'd0);
  endtask

  // Scoreboard consumer, sampled mid-cycle.
  always @(negedge clk) begin
    if (rstn) begin
      if (sb_q.size() == 0)
        chk("no_inst", 64'(inst_valid_o), 64'd0);
      else if (inst_valid_o && inst_ready_i) begin
        mon_exp = sb_q.pop_front();
        chk("inst", {inst_addr_o, inst_o}, mon_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rstn = 1'b0;
    pc_i = 32'h0;
    pc_valid_i = 1'b0;
    hold_i = 1'b0;
    flush_i = 1'b0;
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i = 32'h0;
    inst_ready_i = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req",   64'(imem_req_o),   64'd0);
    chk("rst_addr",  64'(imem_addr_o),  64'd0);
    chk("rst_valid", 64'(inst_valid_o), 64'd0);
    chk("rst_inst",  64'(inst_o),       64'd0);
    chk("rst_iaddr", 64'(inst_addr_o),  64'd0);
    chk("rst_err",   64'(err_o),        64'd0);
    rstn = 1'b1;
    step();

    // Minimum latency fetch of address 0.
    pc_i = 32'h0;
    pc_valid_i = 1'b1;
    #1 chk("t1_pc_ready", 64'(pc_ready_o), 64'd1);
    step();
    pc_valid_i = 1'b0;
    chk("t1_req", 64'(imem_req_o), 64'd1);
    chk("t1_addr", 64'(imem_addr_o), 64'd0);
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
    chk("t1_req_drop", 64'(imem_req_o), 64'd0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'h00000013;
    sb_q.push_back({32'h0, 32'h00000013});
    #1 chk("t1_valid_early", 64'(inst_valid_o), 64'd0);
    step();
    imem_rvalid_i = 1'b0;
    #1 chk("t1_valid", 64'(inst_valid_o), 64'd1);
    chk("t1_inst", 64'(inst_o), 64'h13);
    chk("t1_iaddr", 64'(inst_addr_o), 64'h0);
    step();
    #1 chk("t1_popped", 64'(inst_valid_o), 64'd0);

    // Hold blocks acceptance.
    hold_i = 1'b1;
    pc_i = 32'h50;
    pc_valid_i = 1'b1;
    #1 chk("hold_ready", 64'(pc_ready_o), 64'd0);
    step();
    hold_i = 1'b0;
    pc_valid_i = 1'b0;
    chk("hold_noreq", 64'(imem_req_o), 64'd0);

    // Credit limit with decode stalled.
    inst_ready_i = 1'b0;
    issue(32'h0);
    grant(0);
    issue(32'h4);
    grant(0);
    pc_i = 32'h8;
    pc_valid_i = 1'b1;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'hA0A0_0001;
    sb_q.push_back({32'h0, 32'hA0A0_0001});
    #1 chk("t2_credit_a", 64'(pc_ready_o), 64'd0);
    step();
    imem_rdata_i = 32'hB0B0_0002;
    sb_q.push_back({32'h4, 32'hB0B0_0002});
    #1 chk("t2_credit_b", 64'(pc_ready_o), 64'd0);
    step();
    imem_rvalid_i = 1'b0;
    #1 chk("t2_credit_c", 64'(pc_ready_o), 64'd0);
    chk("t2_valid", 64'(inst_valid_o), 64'd1);
    step();
    inst_ready_i = 1'b1;
    #1 chk("t2_credit_pop", 64'(pc_ready_o), 64'd0);
    step();
    inst_ready_i = 1'b0;
    #1 chk("t2_credit_free", 64'(pc_ready_o), 64'd1);
    step();
    pc_valid_i = 1'b0;
    inst_ready_i = 1'b1;
    grant(0);
    respond(32'hC0C0_0003, 32'h8, 1'b1);
    drain();

    // Flush while waiting for a delayed grant.
    issue(32'h40);
    chk("t3_addr", 64'(imem_addr_o), 64'h40);
    flush_i = 1'b1;
    #1 chk("t3_ready_flush", 64'(pc_ready_o), 64'd0);
    chk("t3_req_flush", 64'(imem_req_o), 64'd1);
    step();
    flush_i = 1'b0;
    chk("t3_req_hold", 64'(imem_req_o), 64'd1);
    chk("t3_addr_hold", 64'(imem_addr_o), 64'h40);
    step();
    chk("t3_req_hold2", 64'(imem_req_o), 64'd1);
    step();
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
    chk("t3_req_done", 64'(imem_req_o), 64'd0);
    issue(32'h100);
    imem_gnt_i = 1'b1;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'hDEAD_BEEF;
    step();
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0;
    respond(32'h1234_5678, 32'h100, 1'b1);
    #1 chk("t3_valid", 64'(inst_valid_o), 64'd1);
    chk("t3_iaddr", 64'(inst_addr_o), 64'h100);
    step();
    drain();

    // Flush coincident with the first of two responses.
    issue(32'h200);
    grant(0);
    issue(32'h204);
    grant(0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'h1111_1111;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    imem_rdata_i = 32'h2222_2222;
    step();
    imem_rvalid_i = 1'b0;
    #1 chk("t4_ready", 64'(pc_ready_o), 64'd1);
    chk("t4_valid", 64'(inst_valid_o), 64'd0);
    step();
    issue(32'h300);
    grant(0);
    respond(32'h3333_3333, 32'h300, 1'b1);
    drain();
    chk("t4_err", 64'(err_o), 64'd0);

    // Stray response sets err_o; reset clears everything.
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'h0BAD_0BAD;
    step();
    imem_rvalid_i = 1'b0;
    chk("t5_err_set", 64'(err_o), 64'd1);
    repeat (3) step();
    chk("t5_err_sticky", 64'(err_o), 64'd1);
    issue(32'h400);
    chk("t5_req_pre", 64'(imem_req_o), 64'd1);
    rstn = 1'b0;
    #1;
    chk("t5_rst_err",   64'(err_o),        64'd0);
    chk("t5_rst_req",   64'(imem_req_o),   64'd0);
    chk("t5_rst_addr",  64'(imem_addr_o),  64'd0);
    chk("t5_rst_valid", 64'(inst_valid_o), 64'd0);
    chk("t5_rst_inst",  64'(inst_o),       64'd0);
    chk("t5_rst_iaddr", 64'(inst_addr_o),  64'd0);
    step();
    rstn = 1'b1;
    step();

    issue(32'h500);
    grant(1);
    respond(32'h5555_0013, 32'h500, 1'b1);
    drain();
    chk("final_err", 64'(err_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
